// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (00..{MAX_HI,MAX_LO}) with up/down, validated load and cascade flags.
// Define BCD_CNT_ALARM_EN to add a loadable alarm register with a combinational match output.
module bcd_mod_counter #(
    parameter int unsigned MAX_HI = 5,
    parameter int unsigned MAX_LO = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_hi,
    input  logic [3:0] load_lo,
`ifdef BCD_CNT_ALARM_EN
    input  logic       alarm_wr,
    input  logic       alarm_on,
    output logic       alarm_match,
`endif
    output logic [3:0] cnt1,
    output logic [3:0] cnt0,
    output logic       carry_out,
    output logic       borrow_out,
    output logic       load_err
);

    localparam logic [3:0] MaxHi  = 4'(MAX_HI);
    localparam logic [3:0] MaxLo  = 4'(MAX_LO);
    localparam logic [7:0] MaxVal = 8'(10 * MAX_HI + MAX_LO);

    logic [3:0] cnt1_q, cnt1_d;
    logic [3:0] cnt0_q, cnt0_d;
    logic       load_err_q, load_err_d;
    logic       at_max, at_zero, data_ok;

    // Both digits must be BCD and the pair must not exceed the terminal value.
    function automatic logic bcd_in_range(input logic [3:0] hi, input logic [3:0] lo);
        logic [7:0] val;
        val = 8'(hi) * 8'd10 + 8'(lo);
        return (hi <= 4'd9) && (lo <= 4'd9) && (val <= MaxVal);
    endfunction

    assign at_max  = (cnt1_q == MaxHi) && (cnt0_q == MaxLo);
    assign at_zero = (cnt1_q == 4'd0) && (cnt0_q == 4'd0);
    assign data_ok = bcd_in_range(load_hi, load_lo);

`ifdef BCD_CNT_ALARM_EN
    logic [3:0] alarm1_q, alarm1_d;
    logic [3:0] alarm0_q, alarm0_d;
`endif

    always_comb begin
        cnt1_d     = cnt1_q;
        cnt0_d     = cnt0_q;
        load_err_d = 1'b0;
        if (load) begin
            if (data_ok) begin
                cnt1_d = load_hi;
                cnt0_d = load_lo;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    cnt1_d = 4'd0;
                    cnt0_d = 4'd0;
                end else if (cnt0_q == 4'd9) begin
                    cnt1_d = cnt1_q + 4'd1;
                    cnt0_d = 4'd0;
                end else begin
                    cnt0_d = cnt0_q + 4'd1;
                end
            end else begin
                if (at_zero) begin
                    cnt1_d = MaxHi;
                    cnt0_d = MaxLo;
                end else if (cnt0_q == 4'd0) begin
                    cnt1_d = cnt1_q - 4'd1;
                    cnt0_d = 4'd9;
                end else begin
                    cnt0_d = cnt0_q - 4'd1;
                end
            end
        end
`ifdef BCD_CNT_ALARM_EN
        alarm1_d = alarm1_q;
        alarm0_d = alarm0_q;
        if (alarm_wr) begin
            if (data_ok) begin
                alarm1_d = load_hi;
                alarm0_d = load_lo;
            end else begin
                load_err_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt1_q     <= 4'd0;
            cnt0_q     <= 4'd0;
            load_err_q <= 1'b0;
        end else begin
            cnt1_q     <= cnt1_d;
            cnt0_q     <= cnt0_d;
            load_err_q <= load_err_d;
        end
    end

`ifdef BCD_CNT_ALARM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm1_q <= 4'd0;
            alarm0_q <= 4'd0;
        end else begin
            alarm1_q <= alarm1_d;
            alarm0_q <= alarm0_d;
        end
    end

    assign alarm_match = alarm_on && (cnt1_q == alarm1_q) && (cnt0_q == alarm0_q);
`endif

    assign cnt1       = cnt1_q;
    assign cnt0       = cnt0_q;
    assign load_err   = load_err_q;
    // Flags are qualified so they can drive the next stage's en directly.
    assign carry_out  = en && up && !load && at_max;
    assign borrow_out = en && !up && !load && at_zero;

endmodule
